// File: rtl/cpu_pkg.sv
// Shared FSM state encodings for the CPU sequencer, control unit and benches.
package cpu_pkg;

  typedef enum logic [2:0] {
    FETCH      = 3'b000,
    DECODE     = 3'b001,
    EXECUTE    = 3'b010,
    MEMORY     = 3'b011,
    WRITEBACK  = 3'b100,
    HALT_STATE = 3'b101,
    IDLE       = 3'b110,
    ILLEGAL    = 3'b111
  } state_e;

  // An instruction is complete once the FSM lands back in FETCH or stops in HALT_STATE.
  function automatic logic ends_instr(input state_e s);
    return (s == FETCH) || (s == HALT_STATE);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] ONE = W'(1);

  always_ff @(posedge clk) begin
    if (clear) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + ONE;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Sequential core for the control_unit: state/IR/ZF registers, run/step debug
// handshake, sticky halt/error flags and saturating activity counters.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       next_state,
  input  logic             ir_we,
  input  logic             zf_we,
  input  logic             halt,
  input  logic [7:0]       mem_rdata,
  input  logic             alu_zero,
  input  logic             run,
  input  logic             step_req,
  output logic [2:0]       state,
  output logic [7:0]       instr,
  output logic             zf,
  output logic             cycle_en,
  output logic             step_ack,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  state_e     state_q, state_d, ns;
  logic [7:0] instr_q;
  logic       zf_q, halted_q, err_q, step_ack_q, step_busy_q;
  logic       ns_illegal, instr_en;

  always_comb begin
    ns         = state_e'(next_state);
    ns_illegal = (ns == ILLEGAL);
    if (halt || ns == HALT_STATE) begin
      state_d = HALT_STATE;
    end else if (ns_illegal) begin
      state_d = FETCH;
    end else begin
      state_d = ns;
    end
  end

  // step_busy tracks "mid-instruction" in both modes so a run->step switch
  // can finish the current instruction before parking in FETCH.
  always_comb begin
    cycle_en = 1'b0;
    if (!halted_q && state_q != HALT_STATE) begin
      cycle_en = run || step_busy_q || (state_q == FETCH && step_req);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FETCH;
      instr_q     <= '0;
      zf_q        <= 1'b0;
      halted_q    <= 1'b0;
      err_q       <= 1'b0;
      step_ack_q  <= 1'b0;
      step_busy_q <= 1'b0;
    end else begin
      step_ack_q <= 1'b0;
      if (cycle_en) begin
        state_q     <= state_d;
        step_busy_q <= !ends_instr(state_d);
        if (ns_illegal) err_q <= 1'b1;
        if (state_d == HALT_STATE) halted_q <= 1'b1;
        if (ir_we) instr_q <= mem_rdata;
        if (zf_we) zf_q <= alu_zero;
        if (!run && ends_instr(state_d)) step_ack_q <= 1'b1;
      end
    end
  end

  assign instr_en = ir_we && cycle_en;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .clear (reset),
    .en    (cycle_en),
    .q     (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clk   (clk),
    .clear (reset),
    .en    (instr_en),
    .q     (instr_count)
  );

  assign state    = state_q;
  assign instr    = instr_q;
  assign zf       = zf_q;
  assign step_ack = step_ack_q;
  assign halted   = halted_q;
  assign err      = err_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: fixed vector table, hand-written step/halt/saturation
// sequences and a randomized run checked against a behavioural model.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        reset, ir_we, zf_we, halt, alu_zero, run, step_req;
  logic [2:0]  next_state;
  logic [7:0]  mem_rdata;

  logic [2:0]  state;
  logic [7:0]  instr;
  logic        zf, cycle_en, step_ack, halted, err;
  logic [15:0] cycle_count, instr_count;

  logic [2:0]  state4;
  logic [7:0]  instr4;
  logic        zf4, cycle_en4, step_ack4, halted4, err4;
  logic [3:0]  cycle_count4, instr_count4;

  int checks = 0;
  int errors = 0;

  // Behavioural model: plain integers, derived from the sequencing rules.
  int m_state, m_instr, m_zf, m_halted, m_err, m_ack;
  int m_cyc, m_icnt, m_cyc4, m_icnt4;
  bit m_en;

  always #5 clk = ~clk;

  cpu_sequencer dut (
    .clk(clk), .reset(reset), .next_state(next_state), .ir_we(ir_we), .zf_we(zf_we),
    .halt(halt), .mem_rdata(mem_rdata), .alu_zero(alu_zero), .run(run), .step_req(step_req),
    .state(state), .instr(instr), .zf(zf), .cycle_en(cycle_en), .step_ack(step_ack),
    .halted(halted), .err(err), .cycle_count(cycle_count), .instr_count(instr_count)
  );

  cpu_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .next_state(next_state), .ir_we(ir_we), .zf_we(zf_we),
    .halt(halt), .mem_rdata(mem_rdata), .alu_zero(alu_zero), .run(run), .step_req(step_req),
    .state(state4), .instr(instr4), .zf(zf4), .cycle_en(cycle_en4), .step_ack(step_ack4),
    .halted(halted4), .err(err4), .cycle_count(cycle_count4), .instr_count(instr_count4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_en();
    if (m_halted != 0 || m_state == 5) return 1'b0;
    if (run) return 1'b1;
    return (m_state != 0) || step_req;
  endfunction

  task automatic model_update();
    int nxt;
    if (reset) begin
      m_state = 0; m_instr = 0; m_zf = 0; m_halted = 0; m_err = 0; m_ack = 0;
      m_cyc = 0; m_icnt = 0; m_cyc4 = 0; m_icnt4 = 0;
    end else begin
      m_ack = 0;
      if (m_en) begin
        nxt = int'(next_state);
        if (nxt == 7) begin m_err = 1; nxt = 0; end
        if (halt || next_state == 3'd5) nxt = 5;
        if (nxt == 5) m_halted = 1;
        if (ir_we) m_instr = int'(mem_rdata);
        if (zf_we) m_zf = int'(alu_zero);
        m_ack   = (!run && (nxt == 0 || nxt == 5)) ? 1 : 0;
        m_state = nxt;
        if (m_cyc < 65535) m_cyc++;
        if (m_cyc4 < 15) m_cyc4++;
        if (ir_we) begin
          if (m_icnt < 65535) m_icnt++;
          if (m_icnt4 < 15) m_icnt4++;
        end
      end
    end
  endtask

  task automatic check_model();
    chk("state",     32'(state),        m_state);
    chk("instr",     32'(instr),        m_instr);
    chk("zf",        32'(zf),           m_zf);
    chk("halted",    32'(halted),       m_halted);
    chk("err",       32'(err),          m_err);
    chk("step_ack",  32'(step_ack),     m_ack);
    chk("cycle_cnt", 32'(cycle_count),  m_cyc);
    chk("instr_cnt", 32'(instr_count),  m_icnt);
    chk("cycle_cnt4", 32'(cycle_count4), m_cyc4);
    chk("instr_cnt4", 32'(instr_count4), m_icnt4);
  endtask

  // Inputs are already driven; settle, check cycle_en, clock, then check outputs.
  task automatic cycle(input bit cmp);
    #1;
    m_en = model_en();
    if (cmp) chk("cycle_en", 32'(cycle_en), 32'(m_en));
    @(posedge clk);
    #1;
    model_update();
    if (cmp) check_model();
  endtask

  // Simple control unit stand-in: FETCH->DECODE->EXECUTE->WRITEBACK->FETCH.
  task automatic drive_cu(input bit rst, input bit r, input bit sreq);
    reset    = rst;
    run      = r;
    step_req = sreq;
    halt     = 1'b0;
    zf_we    = 1'b0;
    alu_zero = 1'b0;
    ir_we    = (m_state == 0);
    mem_rdata = 8'($urandom);
    case (m_state)
      0: next_state = 3'd1;
      1: next_state = 3'd2;
      2: next_state = 3'd4;
      default: next_state = 3'd0;
    endcase
  endtask

  typedef struct {
    logic       rst;
    logic [2:0] ns;
    logic       ir_we;
    logic [7:0] rdata;
    logic       zf_we;
    logic       alu_zero;
    logic [2:0] e_state;
    logic [7:0] e_instr;
    logic       e_zf;
    logic       e_err;
    int         e_cyc;
    int         e_icnt;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int acks;
    int frozen_cyc;
    logic [2:0] ns_pool [6];

    tbl[0]  = '{1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 0, 0};
    tbl[1]  = '{1'b0, 3'd1, 1'b1, 8'h14, 1'b0, 1'b0, 3'd1, 8'h14, 1'b0, 1'b0, 1, 1};
    tbl[2]  = '{1'b0, 3'd2, 1'b0, 8'h00, 1'b0, 1'b0, 3'd2, 8'h14, 1'b0, 1'b0, 2, 1};
    tbl[3]  = '{1'b0, 3'd4, 1'b0, 8'h00, 1'b1, 1'b1, 3'd4, 8'h14, 1'b1, 1'b0, 3, 1};
    tbl[4]  = '{1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h14, 1'b1, 1'b0, 4, 1};
    tbl[5]  = '{1'b0, 3'd1, 1'b1, 8'hA5, 1'b0, 1'b0, 3'd1, 8'hA5, 1'b1, 1'b0, 5, 2};
    tbl[6]  = '{1'b0, 3'd2, 1'b0, 8'h00, 1'b1, 1'b0, 3'd2, 8'hA5, 1'b0, 1'b0, 6, 2};
    tbl[7]  = '{1'b0, 3'd7, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'hA5, 1'b0, 1'b1, 7, 2};
    tbl[8]  = '{1'b0, 3'd1, 1'b1, 8'h3C, 1'b0, 1'b0, 3'd1, 8'h3C, 1'b0, 1'b1, 8, 3};
    tbl[9]  = '{1'b0, 3'd2, 1'b0, 8'h00, 1'b0, 1'b0, 3'd2, 8'h3C, 1'b0, 1'b1, 9, 3};
    tbl[10] = '{1'b1, 3'd3, 1'b1, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 0, 0};
    tbl[11] = '{1'b0, 3'd1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd1, 8'h00, 1'b0, 1'b0, 1, 0};
    tbl[12] = '{1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 2, 0};

    m_state = 0;
    run = 1'b1; step_req = 1'b0; halt = 1'b0;
    for (int i = 0; i < 13; i++) begin
      reset      = tbl[i].rst;
      next_state = tbl[i].ns;
      ir_we      = tbl[i].ir_we;
      mem_rdata  = tbl[i].rdata;
      zf_we      = tbl[i].zf_we;
      alu_zero   = tbl[i].alu_zero;
      cycle(1'b0);
      chk($sformatf("tbl%0d.state", i), 32'(state), 32'(tbl[i].e_state));
      chk($sformatf("tbl%0d.instr", i), 32'(instr), 32'(tbl[i].e_instr));
      chk($sformatf("tbl%0d.zf", i),    32'(zf),    32'(tbl[i].e_zf));
      chk($sformatf("tbl%0d.err", i),   32'(err),   32'(tbl[i].e_err));
      chk($sformatf("tbl%0d.cyc", i),   32'(cycle_count), tbl[i].e_cyc);
      chk($sformatf("tbl%0d.icnt", i),  32'(instr_count), tbl[i].e_icnt);
    end

    // Single-step: idle in FETCH, then one pulse runs exactly one instruction.
    drive_cu(1'b1, 1'b0, 1'b0);
    cycle(1'b1);
    frozen_cyc = m_cyc;
    for (int i = 0; i < 5; i++) begin
      drive_cu(1'b0, 1'b0, 1'b0);
      cycle(1'b1);
    end
    chk("step.frozen_state", 32'(state), 0);
    chk("step.frozen_cyc", 32'(cycle_count), frozen_cyc);
    acks = 0;
    for (int i = 0; i < 7; i++) begin
      drive_cu(1'b0, 1'b0, i == 0);
      cycle(1'b1);
      if (step_ack === 1'b1) acks++;
    end
    chk("step.ack_once", acks, 1);
    chk("step.cyc_after", 32'(cycle_count), frozen_cyc + 4);

    // step_req held high: back-to-back instructions, one ack each.
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      drive_cu(1'b0, 1'b0, 1'b1);
      cycle(1'b1);
      if (step_ack === 1'b1) acks++;
    end
    chk("step.held_acks", acks, 2);

    // run dropped mid-instruction: finish it, then park in FETCH.
    drive_cu(1'b0, 1'b1, 1'b0); cycle(1'b1);
    for (int i = 0; i < 5; i++) begin
      drive_cu(1'b0, 1'b0, 1'b0);
      cycle(1'b1);
    end
    chk("run_drop.parked", 32'(state), 0);

    // Halt in DECODE, then run/step_req activity must not matter.
    drive_cu(1'b1, 1'b1, 1'b0); cycle(1'b1);
    drive_cu(1'b0, 1'b1, 1'b0); cycle(1'b1);
    drive_cu(1'b0, 1'b1, 1'b0); halt = 1'b1; cycle(1'b1);
    chk("halt.state", 32'(state), 5);
    chk("halt.halted", 32'(halted), 1);
    for (int i = 0; i < 6; i++) begin
      drive_cu(1'b0, i[0], ~i[0]);
      cycle(1'b1);
    end
    chk("halt.cycle_en", 32'(cycle_en), 0);
    drive_cu(1'b1, 1'b1, 1'b0); cycle(1'b1);
    chk("halt.reset_clear", 32'(halted), 0);

    // Saturation of the 4-bit instance after 20 running cycles.
    for (int i = 0; i < 20; i++) begin
      drive_cu(1'b0, 1'b1, 1'b0);
      cycle(1'b1);
    end
    chk("sat4.cycle_count", 32'(cycle_count4), 15);
    chk("sat16.cycle_count", 32'(cycle_count), 20);

    // Randomized traffic against the model.
    ns_pool[0] = 3'd0; ns_pool[1] = 3'd1; ns_pool[2] = 3'd2;
    ns_pool[3] = 3'd3; ns_pool[4] = 3'd4; ns_pool[5] = 3'd6;
    run = 1'b1;
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 3)       next_state = 3'd7;
      else if (r < 5)  next_state = 3'd5;
      else             next_state = ns_pool[$urandom_range(0, 5)];
      reset     = ($urandom_range(0, 24) == 0);
      halt      = ($urandom_range(0, 49) == 0);
      ir_we     = 1'($urandom);
      zf_we     = 1'($urandom);
      alu_zero  = 1'($urandom);
      mem_rdata = 8'($urandom);
      step_req  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) run = ~run;
      cycle(1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
